id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_if.sv | 75 +++++++
 rtl/id_ex_reg.sv | 140 ++++++++++++++
 tb/tb_id_ex_reg.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline boundary: ID-stage inputs, registered EX-stage view, and the
// load-use hazard feedback (stall_out, bubble_count) returned to the front end.
interface id_ex_reg_if;
   // ID-stage control bits, aligned with the ID data in the same cycle
   logic        mem_to_reg_in;
   logic        reg_write_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic        beq_instruction_in;
   logic        aluSrc_in;
   logic [1:0]  aluOp_in;
   logic [31:0] read_data1_in;
   logic [31:0] read_data2_in;
   logic [31:0] imm_in;
   logic [31:0] pc_in;
   logic [4:0]  rs1_in;
   logic [4:0]  rs2_in;
   logic [4:0]  rd_in;
   logic [2:0]  funct3_in;
   logic        funct7b5_in;
   logic        valid_in;
   logic        flush;

   // Registered EX-stage view
   logic        mem_to_reg_out;
   logic        reg_write_out;
   logic        mem_read_out;
   logic        mem_write_out;
   logic        beq_instruction_out;
   logic        aluSrc_out;
   logic [1:0]  aluOp_out;
   logic [31:0] read_data1_out;
   logic [31:0] read_data2_out;
   logic [31:0] imm_out;
   logic [31:0] pc_out;
   logic [4:0]  rs1_out;
   logic [4:0]  rs2_out;
   logic [4:0]  rd_out;
   logic [2:0]  funct3_out;
   logic        funct7b5_out;
   logic        valid_out;

   // Handshake: there is no ready; while stall_out is high the ID stage must
   // hold its instruction (PC and IF/ID frozen) and re-present it next cycle.
   logic        stall_out;
   logic [7:0]  bubble_count;

   // Driven by the ID stage (or a testbench standing in for it)
   modport master (
      output mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in,
             beq_instruction_in, aluSrc_in, aluOp_in,
             read_data1_in, read_data2_in, imm_in, pc_in,
             rs1_in, rs2_in, rd_in, funct3_in, funct7b5_in,
             valid_in, flush,
      input  mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
             beq_instruction_out, aluSrc_out, aluOp_out,
             read_data1_out, read_data2_out, imm_out, pc_out,
             rs1_out, rs2_out, rd_out, funct3_out, funct7b5_out,
             valid_out, stall_out, bubble_count
   );

   // Used by the pipeline register itself
   modport slave (
      input  mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in,
             beq_instruction_in, aluSrc_in, aluOp_in,
             read_data1_in, read_data2_in, imm_in, pc_in,
             rs1_in, rs2_in, rd_in, funct3_in, funct7b5_in,
             valid_in, flush,
      output mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
             beq_instruction_out, aluSrc_out, aluOp_out,
             read_data1_out, read_data2_out, imm_out, pc_out,
             rs1_out, rs2_out, rd_out, funct3_out, funct7b5_out,
             valid_out, stall_out, bubble_count
   );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and a saturating count of hazard bubbles.
module id_ex_reg (
   input  logic       clock,
   input  logic       reset,
   id_ex_reg_if.slave bus
);

   typedef struct packed {
      logic        mem_to_reg;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        beq_instruction;
      logic        alu_src;
      logic [1:0]  alu_op;
      logic [31:0] read_data1;
      logic [31:0] read_data2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic        valid;
   } stage_t;

   typedef enum logic [1:0] {
      ACT_LOAD  = 2'd0,
      ACT_STALL = 2'd1,
      ACT_FLUSH = 2'd2
   } action_e;

   localparam logic [7:0] BUBBLE_MAX = 8'hFF;

   stage_t     stage_in;
   stage_t     stage_d;
   stage_t     stage_q;
   logic [7:0] bubble_count_d;
   logic [7:0] bubble_count_q;
   logic       src_match;
   logic       stall;
   action_e    action;

   // Gather the ID inputs; an invalid slot keeps its data but loses all control
   always_comb begin
      stage_in                 = '0;
      stage_in.mem_to_reg      = bus.mem_to_reg_in;
      stage_in.reg_write       = bus.reg_write_in;
      stage_in.mem_read        = bus.mem_read_in;
      stage_in.mem_write       = bus.mem_write_in;
      stage_in.beq_instruction = bus.beq_instruction_in;
      stage_in.alu_src         = bus.aluSrc_in;
      stage_in.alu_op          = bus.aluOp_in;
      stage_in.read_data1      = bus.read_data1_in;
      stage_in.read_data2      = bus.read_data2_in;
      stage_in.imm             = bus.imm_in;
      stage_in.pc              = bus.pc_in;
      stage_in.rs1             = bus.rs1_in;
      stage_in.rs2             = bus.rs2_in;
      stage_in.rd              = bus.rd_in;
      stage_in.funct3          = bus.funct3_in;
      stage_in.funct7b5        = bus.funct7b5_in;
      stage_in.valid           = bus.valid_in;
      if (!bus.valid_in) begin
         stage_in.mem_to_reg      = 1'b0;
         stage_in.reg_write       = 1'b0;
         stage_in.mem_read        = 1'b0;
         stage_in.mem_write       = 1'b0;
         stage_in.beq_instruction = 1'b0;
         stage_in.alu_src         = 1'b0;
         stage_in.alu_op          = 2'b00;
      end
   end

   // x0 is never a real producer, so rd == 0 cannot create a dependency
   assign src_match = (stage_q.rd == bus.rs1_in) || (stage_q.rd == bus.rs2_in);
   assign stall     = bus.valid_in && stage_q.valid && stage_q.mem_read &&
                      (stage_q.rd != 5'd0) && src_match && !bus.flush;

   always_comb begin
      action = ACT_LOAD;
      if (bus.flush) begin
         action = ACT_FLUSH;
      end else if (stall) begin
         action = ACT_STALL;
      end
   end

   always_comb begin
      stage_d        = stage_in;
      bubble_count_d = bubble_count_q;
      case (action)
         ACT_FLUSH: begin
            stage_d = '0;
         end
         ACT_STALL: begin
            stage_d = '0;
            if (bubble_count_q != BUBBLE_MAX) begin
               bubble_count_d = bubble_count_q + 8'd1;
            end
         end
         default: begin
            stage_d = stage_in;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stage_q        <= '0;
         bubble_count_q <= '0;
      end else begin
         stage_q        <= stage_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   assign bus.mem_to_reg_out      = stage_q.mem_to_reg;
   assign bus.reg_write_out       = stage_q.reg_write;
   assign bus.mem_read_out        = stage_q.mem_read;
   assign bus.mem_write_out       = stage_q.mem_write;
   assign bus.beq_instruction_out = stage_q.beq_instruction;
   assign bus.aluSrc_out          = stage_q.alu_src;
   assign bus.aluOp_out           = stage_q.alu_op;
   assign bus.read_data1_out      = stage_q.read_data1;
   assign bus.read_data2_out      = stage_q.read_data2;
   assign bus.imm_out             = stage_q.imm;
   assign bus.pc_out              = stage_q.pc;
   assign bus.rs1_out             = stage_q.rs1;
   assign bus.rs2_out             = stage_q.rs2;
   assign bus.rd_out              = stage_q.rd;
   assign bus.funct3_out          = stage_q.funct3;
   assign bus.funct7b5_out        = stage_q.funct7b5;
   assign bus.valid_out           = stage_q.valid;
   assign bus.stall_out           = stall;
   assign bus.bubble_count        = bubble_count_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: each cycle's stimulus pushes its expected
// stall/bubble_count/register image; a monitor pops and compares.
module tb_id_ex_reg;

   typedef struct packed {
      logic        mem_to_reg;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        beq;
      logic        alu_src;
      logic [1:0]  alu_op;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic        valid;
   } vec_t;

   localparam int VW = $bits(vec_t);
   localparam int EW = VW + 10;
   localparam int K_LOAD = 0;
   localparam int K_MASK = 1;
   localparam int K_ZERO = 2;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   mon_idx = 0;
   logic [EW-1:0] exp_q[$];

   id_ex_reg_if bus();

   id_ex_reg dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input logic m2r, input logic rw, input logic mr,
                               input logic mw, input logic beq, input logic asrc,
                               input logic [1:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic valid, input logic [7:0] tag);
      vec_t v;
      v.mem_to_reg = m2r;
      v.reg_write  = rw;
      v.mem_read   = mr;
      v.mem_write  = mw;
      v.beq        = beq;
      v.alu_src    = asrc;
      v.alu_op     = op;
      v.rd1        = {24'h11A0B0, tag};
      v.rd2        = {24'h22C0D0, tag};
      v.imm        = {24'hFFFF80, tag};
      v.pc         = {24'h004000, tag};
      v.rs1        = rs1;
      v.rs2        = rs2;
      v.rd         = rd;
      v.funct3     = tag[2:0];
      v.funct7b5   = tag[3];
      v.valid      = valid;
      return v;
   endfunction

   function automatic vec_t rtype(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic [7:0] tag);
      return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, rs1, rs2, rd, 1'b1, tag);
   endfunction

   function automatic vec_t load(input logic [4:0] rs1, input logic [4:0] rd,
                                 input logic [7:0] tag);
      return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, rs1, 5'd0, rd, 1'b1, tag);
   endfunction

   function automatic vec_t store(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [7:0] tag);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, rs1, rs2, 5'd0, 1'b1, tag);
   endfunction

   function automatic logic [7:0] sat(input int n);
      logic [31:0] w;
      w = n;
      return (n > 255) ? 8'hFF : w[7:0];
   endfunction

   function automatic vec_t read_dut();
      vec_t v;
      v.mem_to_reg = bus.mem_to_reg_out;
      v.reg_write  = bus.reg_write_out;
      v.mem_read   = bus.mem_read_out;
      v.mem_write  = bus.mem_write_out;
      v.beq        = bus.beq_instruction_out;
      v.alu_src    = bus.aluSrc_out;
      v.alu_op     = bus.aluOp_out;
      v.rd1        = bus.read_data1_out;
      v.rd2        = bus.read_data2_out;
      v.imm        = bus.imm_out;
      v.pc         = bus.pc_out;
      v.rs1        = bus.rs1_out;
      v.rs2        = bus.rs2_out;
      v.rd         = bus.rd_out;
      v.funct3     = bus.funct3_out;
      v.funct7b5   = bus.funct7b5_out;
      v.valid      = bus.valid_out;
      return v;
   endfunction

   task automatic drive_vec(input vec_t v, input logic rst, input logic fl);
      bus.mem_to_reg_in      = v.mem_to_reg;
      bus.reg_write_in       = v.reg_write;
      bus.mem_read_in        = v.mem_read;
      bus.mem_write_in       = v.mem_write;
      bus.beq_instruction_in = v.beq;
      bus.aluSrc_in          = v.alu_src;
      bus.aluOp_in           = v.alu_op;
      bus.read_data1_in      = v.rd1;
      bus.read_data2_in      = v.rd2;
      bus.imm_in             = v.imm;
      bus.pc_in              = v.pc;
      bus.rs1_in             = v.rs1;
      bus.rs2_in             = v.rs2;
      bus.rd_in              = v.rd;
      bus.funct3_in          = v.funct3;
      bus.funct7b5_in        = v.funct7b5;
      bus.valid_in           = v.valid;
      bus.flush              = fl;
      reset                  = rst;
   endtask

   // One cycle: apply inputs at negedge, queue what the next edge must produce
   task automatic step(input vec_t v, input logic rst, input logic fl, input int kind,
                       input logic chk_st, input logic exp_st, input logic [7:0] exp_bc);
      vec_t e;
      @(negedge clock);
      drive_vec(v, rst, fl);
      case (kind)
         K_LOAD: e = v;
         K_MASK: begin
            e = v;
            e.mem_to_reg = 1'b0;
            e.reg_write  = 1'b0;
            e.mem_read   = 1'b0;
            e.mem_write  = 1'b0;
            e.beq        = 1'b0;
            e.alu_src    = 1'b0;
            e.alu_op     = 2'b00;
            e.valid      = 1'b0;
         end
         default: e = '0;
      endcase
      exp_q.push_back({chk_st, exp_st, exp_bc, e});
   endtask

   // Monitor: stall_out is checked once inputs settle, registers after the edge
   initial begin
      logic [EW-1:0] ent;
      vec_t got;
      vec_t want;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() != 0) begin
            ent = exp_q.pop_front();
            mon_idx++;
            if (ent[EW-1]) begin
               checks++;
               if (bus.stall_out !== ent[EW-2]) begin
                  errors++;
                  $display("FAIL stall_out cycle %0d: got %b expected %b", mon_idx, bus.stall_out, ent[EW-2]);
               end
            end
            @(posedge clock);
            #1;
            got  = read_dut();
            want = ent[VW-1:0];
            checks++;
            if (bus.bubble_count !== ent[VW+7:VW]) begin
               errors++;
               $display("FAIL bubble_count cycle %0d: got %0d expected %0d", mon_idx, bus.bubble_count, ent[VW+7:VW]);
            end
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL id_ex_outputs cycle %0d: got %h expected %h", mon_idx, got, want);
            end
         end
      end
   end

   initial begin
      #40000;
      errors++;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      drive_vec('0, 1'b1, 1'b0);

      // Reset with arbitrary inputs; first stall view depends on unreset state
      step(mk(1,1,1,1,1,1,2'b11,5'd9,5'd9,5'd9,1'b1,8'h5A), 1'b1, 1'b0, K_ZERO, 1'b0, 1'b0, 8'd0);
      step(mk(1,1,1,1,1,1,2'b11,5'd9,5'd9,5'd9,1'b0,8'h3C), 1'b1, 1'b0, K_ZERO, 1'b1, 1'b0, 8'd0);
      // R-type, no hazard
      step(rtype(5'd1, 5'd2, 5'd5, 8'h03), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd0);
      // Load r7, dependent R-type stalls once, then is captured
      step(load(5'd5, 5'd7, 8'h04), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd0);
      step(rtype(5'd7, 5'd2, 5'd8, 8'h05), 1'b0, 1'b0, K_ZERO, 1'b1, 1'b1, 8'd1);
      step(rtype(5'd7, 5'd2, 5'd8, 8'h05), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd1);
      // Hazard through rs2
      step(load(5'd8, 5'd3, 8'h07), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd1);
      step(store(5'd0, 5'd3, 8'h08), 1'b0, 1'b0, K_ZERO, 1'b1, 1'b1, 8'd2);
      step(store(5'd0, 5'd3, 8'h08), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd2);
      // Load to x0 followed by x0 readers: no stall
      step(load(5'd0, 5'd0, 8'h0A), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd2);
      step(rtype(5'd0, 5'd0, 5'd4, 8'h0B), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd2);
      // Hazard masked by flush: bubble, count unchanged
      step(load(5'd4, 5'd7, 8'h0C), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd2);
      step(rtype(5'd7, 5'd1, 5'd8, 8'h0D), 1'b0, 1'b1, K_ZERO, 1'b1, 1'b0, 8'd2);
      // Invalid slot after a load: no stall, control masked, data captured
      step(load(5'd1, 5'd7, 8'h0E), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd2);
      step(mk(1,1,1,1,1,1,2'b11,5'd7,5'd3,5'd12,1'b0,8'h0F), 1'b0, 1'b0, K_MASK, 1'b1, 1'b0, 8'd2);
      step(rtype(5'd12, 5'd7, 5'd13, 8'h10), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd2);
      // Reset during a live hazard wins and clears the count
      step(load(5'd13, 5'd6, 8'h11), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd2);
      step(rtype(5'd1, 5'd6, 5'd2, 8'h12), 1'b1, 1'b0, K_ZERO, 1'b1, 1'b1, 8'd0);

      // 260 load-use hazards: count must stop at 255
      for (int i = 1; i <= 260; i++) begin
         step(load(5'd1, 5'd9, sat(i)), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, sat(i - 1));
         step(rtype(5'd9, 5'd2, 5'd10, sat(i)), 1'b0, 1'b0, K_ZERO, 1'b1, 1'b1, sat(i));
      end
      step(load(5'd1, 5'd9, 8'h21), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd255);
      step(rtype(5'd9, 5'd2, 5'd10, 8'h22), 1'b0, 1'b1, K_ZERO, 1'b1, 1'b0, 8'd255);
      step(rtype(5'd9, 5'd2, 5'd10, 8'h23), 1'b0, 1'b0, K_LOAD, 1'b1, 1'b0, 8'd255);
      step(mk(1,0,1,0,1,0,2'b01,5'd10,5'd10,5'd10,1'b1,8'h24), 1'b1, 1'b0, K_ZERO, 1'b1, 1'b0, 8'd0);

      @(negedge clock);
      drive_vec('0, 1'b0, 1'b0);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(posedge clock);
      end
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      @(posedge clock);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
